// File: rtl/riscv_pkg.sv
// riscv_pkg: shared byte-enable encodings and memory arbiter enums
package riscv_pkg;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} mem_arb_state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} mem_owner_e;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: fetch/data winner select with starvation counter, or round-robin pointer under MEM_ARB_RR_EN
module mem_arb_picker
  import riscv_pkg::*;
`ifndef MEM_ARB_RR_EN
  #(parameter int STARVE_LIMIT = 4)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic instr_req,
  input  logic data_req,
  output logic instr_win,
  output logic data_win
);
  always_comb instr_win = arb_en && instr_req && !data_win;
`ifdef MEM_ARB_RR_EN
  mem_owner_e last;
  always_comb data_win = arb_en && data_req && !(instr_req && last == OWN_DATA);
  always_ff @(posedge clk)
    if (reset) last <= OWN_INSTR;
    else if (instr_win || data_win) last <= data_win ? OWN_DATA : OWN_INSTR;
`else
  logic [3:0] cnt;
  always_comb data_win = arb_en && data_req && !(instr_req && cnt == 4'(STARVE_LIMIT));
  always_ff @(posedge clk)
    if (reset || instr_win || (data_win && !instr_req)) cnt <= '0;
    else if (data_win && cnt != 4'hf) cnt <= cnt + 4'd1;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding fetch/data memory port arbiter; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
  import riscv_pkg::*;
`ifndef MEM_ARB_RR_EN
  #(parameter int STARVE_LIMIT = 4)
`endif
  (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  mem_arb_state_e state;
  mem_owner_e owner;
  logic instr_win, data_win;
  mem_arb_picker
`ifndef MEM_ARB_RR_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
    u_picker (
    .clk(clk),
    .reset(reset),
    .arb_en(state == IDLE),
    .instr_req(instr_req_i),
    .data_req(data_req_i),
    .instr_win(instr_win),
    .data_win(data_win)
  );
  assign instr_gnt_o = instr_win;
  assign data_gnt_o = data_win;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_INSTR;
      mem_req_o <= 1'b0;
      mem_addr_o <= '0;
      mem_byte_en_o <= '0;
      mem_wr_o <= 1'b0;
      mem_wr_data_o <= '0;
      instr_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      instr_rdata_o <= '0;
      data_rdata_o <= '0;
    end else begin
      instr_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      case (state)
        IDLE:
          if (instr_win || data_win) begin
            state <= ISSUE;
            mem_req_o <= 1'b1;
            owner <= data_win ? OWN_DATA : OWN_INSTR;
            mem_addr_o <= data_win ? data_addr_i : instr_addr_i;
            mem_byte_en_o <= data_win ? data_byte_en_i : WORD;
            mem_wr_o <= data_win && data_wr_i;
            mem_wr_data_o <= data_win ? data_wr_data_i : '0;
          end
        ISSUE:
          if (mem_gnt_i) begin
            state <= WAIT_RSP;
            mem_req_o <= 1'b0;
          end
        WAIT_RSP:
          if (mem_rvalid_i) begin
            state <= IDLE;
            if (owner == OWN_DATA) begin
              data_rvalid_o <= 1'b1;
              data_rdata_o <= mem_rdata_i;
            end else begin
              instr_rvalid_o <= 1'b1;
              instr_rdata_o <= mem_rdata_i;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, per-cycle model compare and literal checks for mem_port_arbiter
module tb_mem_port_arbiter;
  import riscv_pkg::*;
  localparam int LIMIT = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic instr_req_i = 1'b0, data_req_i = 1'b0, data_wr_i = 1'b0;
  logic [31:0] instr_addr_i = '0, data_addr_i = '0, data_wr_data_i = '0;
  logic [1:0] data_byte_en_i = '0;
  logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, mem_req_o, mem_wr_o, busy_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wr_data_o;
  logic [1:0] mem_byte_en_o;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_en_i(data_byte_en_i),
    .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );
  int errors = 0, checks = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  int gnt_delay = 0, rsp_delay = 0, gc = 0, rc = -1;
  logic [31:0] rsp_data = 32'hdeadbeef;
  bit spur = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = spur;
    if (rc >= 0) begin
      if (rc == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rsp_data;
        rsp_data = rsp_data + 32'h11;
      end
      rc--;
    end else if (mem_req_o) begin
      if (gc == gnt_delay) begin
        mem_gnt_i = 1'b1;
        gc = 0;
        rc = rsp_delay;
      end else gc++;
    end
  end
  int m_ph = 0, m_cnt = 0;
  bit m_own_d, m_wr, m_rv_i, m_rv_d, m_last_d, armed = 1'b0;
  logic [31:0] m_addr, m_wd, m_rd_i, m_rd_d;
  logic [1:0] m_be;
  function automatic bit data_wins();
`ifdef MEM_ARB_RR_EN
    return !(instr_req_i && m_last_d);
`else
    return !(instr_req_i && m_cnt >= LIMIT);
`endif
  endfunction
  always @(posedge clk) begin
    automatic bit dg = m_ph == 0 && data_req_i && data_wins();
    automatic bit ig = m_ph == 0 && instr_req_i && !dg;
    if (reset) begin
      armed <= 1'b1;
      m_ph <= 0;
      m_cnt <= 0;
      m_last_d <= 1'b0;
      m_own_d <= 1'b0;
      m_rv_i <= 1'b0;
      m_rv_d <= 1'b0;
      m_rd_i <= '0;
      m_rd_d <= '0;
      m_addr <= '0;
      m_be <= '0;
      m_wr <= 1'b0;
      m_wd <= '0;
    end else begin
      m_rv_i <= 1'b0;
      m_rv_d <= 1'b0;
      if (dg || ig) begin
        m_ph <= 1;
        m_own_d <= dg;
        m_addr <= dg ? data_addr_i : instr_addr_i;
        m_be <= dg ? data_byte_en_i : WORD;
        m_wr <= dg && data_wr_i;
        m_wd <= dg ? data_wr_data_i : '0;
        m_last_d <= dg;
        m_cnt <= (dg && instr_req_i) ? m_cnt + 1 : 0;
      end else if (m_ph == 1 && mem_gnt_i) m_ph <= 2;
      else if (m_ph == 2 && mem_rvalid_i) begin
        m_ph <= 0;
        if (m_own_d) begin
          m_rv_d <= 1'b1;
          m_rd_d <= mem_rdata_i;
        end else begin
          m_rv_i <= 1'b1;
          m_rd_i <= mem_rdata_i;
        end
      end
    end
  end
  always @(negedge clk) if (armed) begin
    automatic bit dg = m_ph == 0 && data_req_i && data_wins();
    automatic bit ig = m_ph == 0 && instr_req_i && !dg;
    chk("instr_gnt", instr_gnt_o, ig);
    chk("data_gnt", data_gnt_o, dg);
    chk("instr_rvalid", instr_rvalid_o, m_rv_i);
    chk("data_rvalid", data_rvalid_o, m_rv_d);
    chk("instr_rdata", instr_rdata_o, m_rd_i);
    chk("data_rdata", data_rdata_o, m_rd_d);
    chk("mem_req", mem_req_o, m_ph == 1);
    chk("busy", busy_o, m_ph != 0);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_byte_en", mem_byte_en_o, m_be);
    chk("mem_wr", mem_wr_o, m_wr);
    chk("mem_wr_data", mem_wr_data_o, m_wd);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] got = '0;
    int n = 0, hold = 0, seen = 0, rv = 0;
    bit found = 1'b0, dg, ig;
    repeat (2) tick();
    at_neg();
    chk("reset_busy", busy_o, 0);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    tick();
    reset = 1'b0;
    tick();
    data_req_i = 1'b1;
    data_addr_i = 32'h100;
    data_byte_en_i = WORD;
    at_neg();
    chk("t1_data_gnt", data_gnt_o, 1);
    chk("t1_instr_gnt", instr_gnt_o, 0);
    tick();
    data_req_i = 1'b0;
    at_neg();
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_mem_addr", mem_addr_o, 32'h100);
    repeat (2) tick();
    at_neg();
    chk("t1_data_rvalid", data_rvalid_o, 1);
    chk("t1_data_rdata", data_rdata_o, 32'hdeadbeef);
    chk("t1_instr_rvalid", instr_rvalid_o, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_req_i = 1'b1;
    instr_addr_i = 32'h1000;
    data_req_i = 1'b1;
    data_addr_i = 32'h2000;
    for (int c = 0; c < 60 && n < 6; c++) begin
      at_neg();
      dg = data_gnt_o;
      ig = instr_gnt_o;
      if (dg || ig) begin
        got[n] = dg;
        n++;
      end
      tick();
      if (dg) data_addr_i = data_addr_i + 4;
      if (ig) instr_addr_i = instr_addr_i + 4;
    end
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    chk("t2_grant_count", n, 6);
`ifdef MEM_ARB_RR_EN
    chk("t2_grant_order", got, 6'b010101);
`else
    chk("t2_grant_order", got, 6'b101111);
`endif
    repeat (4) tick();
    gnt_delay = 5;
    data_req_i = 1'b1;
    data_addr_i = 32'h200;
    data_byte_en_i = HALF_WORD;
    data_wr_i = 1'b1;
    data_wr_data_i = 32'h12345678;
    at_neg();
    chk("t3_data_gnt", data_gnt_o, 1);
    tick();
    data_req_i = 1'b0;
    data_wr_i = 1'b0;
    instr_req_i = 1'b1;
    instr_addr_i = 32'h3000;
    repeat (6) begin
      at_neg();
      hold += int'(mem_req_o && mem_addr_o == 32'h200 && mem_wr_o && mem_wr_data_o == 32'h12345678);
      seen += int'(instr_gnt_o || data_gnt_o);
      tick();
    end
    gnt_delay = 0;
    chk("t3_req_stable", hold, 6);
    chk("t3_no_grant", seen, 0);
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (instr_gnt_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_fetch_gnt", found, 1);
    tick();
    instr_req_i = 1'b0;
    at_neg();
    chk("t3_fetch_addr", mem_addr_o, 32'h3000);
    chk("t3_fetch_be", mem_byte_en_o, WORD);
    chk("t3_fetch_wr", mem_wr_o, 0);
    repeat (4) tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    at_neg();
    chk("t4_spur_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    tick();
    rsp_delay = 4;
    data_req_i = 1'b1;
    data_addr_i = 32'h400;
    data_byte_en_i = WORD;
    tick();
    data_req_i = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_delay = 0;
    at_neg();
    chk("t5_busy", busy_o, 0);
    chk("t5_mem_req", mem_req_o, 0);
    chk("t5_mem_addr", mem_addr_o, 0);
    repeat (8) begin
      at_neg();
      rv += int'(instr_rvalid_o || data_rvalid_o);
      tick();
    end
    chk("t5_no_rvalid", rv, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester and the data-memory interface. Requests are captured into a one-deep transaction register, issued to memory with a req/gnt handshake, and the response is routed back to the owning requester. It sits between the core's fetch and load/store paths and the unified memory model, with one transaction outstanding at a time.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch is pending in fixed-priority mode; range 1–15.
- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_req_i`  in  1  fetch request; held with its address until `instr_gnt_o`.
- `instr_addr_i`  in  32  fetch address.
- `instr_gnt_o`  out  1  fetch request captured this cycle.
- `instr_rvalid_o`  out  1  one-cycle pulse; `instr_rdata_o` is valid.
- `instr_rdata_o`  out  32  fetched word.
- `data_req_i`, `data_addr_i` (32), `data_byte_en_i` (2), `data_wr_i`, `data_wr_data_i` (32)  in  data request; held until `data_gnt_o`.
- `data_gnt_o`  out  1  data request captured this cycle.
- `data_rvalid_o`  out  1  one-cycle pulse; read data or write acknowledge.
- `data_rdata_o`  out  32  raw memory word. Extension is done downstream.
- `mem_req_o`, `mem_addr_o` (32), `mem_byte_en_o` (2), `mem_wr_o`, `mem_wr_data_o` (32)  out  memory request; all registered.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`  in  1  memory response; also acknowledges writes.
- `mem_rdata_i`  in  32  memory read data.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT_RSP. State encoding is in the package.
- **IDLE**
  - If any request is present, pick a winner, assert its `*_gnt_o` combinationally and latch the transaction plus an owner flag.
  - Go to ISSUE.
  - The loser sees no gnt and must keep its request held.
- **ISSUE**
  - `mem_req_o`=1 with the latched fields.
  - On `mem_gnt_i`, go to WAIT_RSP.
  - The request stays stable until granted.
- **WAIT_RSP**
  - `mem_req_o`=0.
  - On `mem_rvalid_i`, register `mem_rdata_i` into the owner's rdata and pulse the owner's rvalid on the next cycle. Go to IDLE.
- **Fetch transactions** are forced to byte_en=WORD, wr=0 and wr_data=0.
- **Fixed priority** (default):
  - Data wins over fetch.
  - A 4-bit saturating counter counts consecutive data grants made while `instr_req_i` is high.
  - When the count equals `STARVE_LIMIT`, fetch wins the next arbitration.
  - The counter clears on any fetch grant, or whenever `instr_req_i` is low at a data grant.
- **Spurious responses:** `mem_rvalid_i` in IDLE or ISSUE is ignored and produces no rvalid.
- **Same-cycle re-arbitration:** IDLE is entered in the same cycle the rvalid pulse is output, so a new grant may coincide with that pulse.

## Timing
- **Reset values:** every output is 0, the state is IDLE, the starvation counter is 0 and the round-robin pointer favours data.
- **Reset mid-transaction:** the transaction is abandoned with no rvalid, and `mem_req_o` drops on the next edge.
- **Minimum latency**, with `mem_gnt_i` granted in the first ISSUE cycle and `mem_rvalid_i` one cycle after:
  - cycle 0: req and gnt
  - cycle 1: `mem_req_o`
  - cycle 2: `mem_rvalid_i`
  - cycle 3: requester rvalid
- **Throughput:** the next grant is possible in cycle 3, so one transaction takes at least 3 cycles.
- **Held outputs:** rdata holds its value until that requester's next response. `*_gnt_o` is never high while not in IDLE.
- **Simultaneous events:** both requesters in the same IDLE cycle produce exactly one gnt.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Arbitration is round-robin. A 1-bit last-owner pointer gives the other requester priority when both request.
  - The starvation counter and `STARVE_LIMIT` are not compiled.
- `MEM_ARB_RR_EN` undefined: fixed data priority with the starvation counter, as described above.

## Structure
- The shared package `riscv_pkg` holds:
  - the `BYTE`/`HALF_WORD`/`WORD` byte-enable encodings (already present);
  - a new `mem_arb_state_e` enum (IDLE, ISSUE, WAIT_RSP);
  - a new `mem_owner_e` enum (OWN_INSTR, OWN_DATA).
- Optional sub-module `mem_arb_picker`: combinational winner selection plus the counter or pointer update. The FSM and datapath registers stay in the top module.

## Test plan
- **Single data read:** `data_req_i`, addr 0x100, byte_en=WORD; memory grants immediately and returns 0xDEADBEEF one cycle later.
  - `data_gnt_o` in cycle 0, `mem_req_o` in cycle 1.
  - `data_rvalid_o` in cycle 3 with 0xDEADBEEF; `instr_rvalid_o` stays 0.
- **Simultaneous requests, fixed priority:** data wins and fetch stays held.
  - With data requesting continuously and `STARVE_LIMIT`=4, the 5th arbitration grants fetch.
- **`MEM_ARB_RR_EN`:** both requesters held high give alternating grants I/D/I/D after an initial D.
- **Memory backpressure:** `mem_gnt_i` low for 5 cycles.
  - `mem_req_o` and its fields stay stable for 6 cycles.
  - No new grants during that time.
- **Reset in WAIT_RSP:** no rvalid pulse, all outputs 0 the next cycle, and a later `mem_rvalid_i` is ignored.
- **Fetch and spurious response:**
  - A fetch while `data_byte_en_i` is set to HALF_WORD produces `mem_byte_en_o`=WORD and `mem_wr_o`=0.
  - A spurious `mem_rvalid_i` in IDLE produces no rvalid.
